// File: rtl/ecs_pkg.sv
// Shared constants, token payload layout and FSM state encoding for the ECS stream encoder.
package ecs_pkg;

  localparam int GRP_W     = 4;
  localparam int PAYLOAD_W = 6;

  localparam int OFF_NOI  = 4;
  localparam int OFF_IND0 = 2;
  localparam int OFF_IND1 = 0;
  localparam int OFF_RAW  = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // Escape tokens carry the raw nibble; others carry {noi, ind0, ind1}.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic             esc,
    input logic [GRP_W-1:0] raw,
    input logic [1:0]       noi,
    input logic [1:0]       ind0,
    input logic [1:0]       ind1
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    if (esc) begin
      p[OFF_RAW +: GRP_W] = raw;
    end else begin
      p[OFF_NOI +: 2]  = noi;
      p[OFF_IND0 +: 2] = ind0;
      p[OFF_IND1 +: 2] = ind1;
    end
    return p;
  endfunction

endpackage

// File: rtl/ecs_nibble_coder.sv
// Combinational nibble coder: popcount, lowest two set positions, escape flag for >= 3 ones.
module ecs_nibble_coder
  import ecs_pkg::*;
(
  input  logic [GRP_W-1:0] nib_i,
  output logic             esc_o,
  output logic [1:0]       noi_o,
  output logic [1:0]       ind0_o,
  output logic [1:0]       ind1_o
);

  logic [2:0] ones;

  always_comb begin
    ones   = '0;
    ind0_o = '0;
    ind1_o = '0;
    for (int i = 0; i < GRP_W; i++) begin
      if (nib_i[i]) begin
        if (ones == 3'd0) begin
          ind0_o = 2'(i);
        end else if (ones == 3'd1) begin
          ind1_o = 2'(i);
        end
        ones = ones + 3'd1;
      end
    end
    esc_o = (ones >= 3'd3);
    noi_o = esc_o ? 2'd0 : ones[1:0];
  end

endmodule

// File: rtl/ecs_stream_encoder.sv
// Splits each accepted word into per-nibble tokens, one per token handshake, optionally skipping
// zero nibbles; a new word may be accepted on the final token's handshake for gap-free streaming.
module ecs_stream_encoder
  import ecs_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int CNT_W = 16,
  localparam int NG   = W_IN / GRP_W,
  localparam int PW   = $clog2(NG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_IN-1:0]      in_data,
  input  logic                 in_skip,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tok_valid,
  input  logic                 tok_ready,
  output logic                 tok_esc,
  output logic [PAYLOAD_W-1:0] tok_payload,
  output logic [PW-1:0]        tok_pos,
  output logic                 tok_last,
  output logic [CNT_W-1:0]     esc_count
);

  state_e            state_q, state_d;
  logic [W_IN-1:0]   word_q, word_d;
  logic              skip_q, skip_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [GRP_W-1:0]  nib;
  logic              c_esc;
  logic [1:0]        c_noi, c_ind0, c_ind1;
  logic              emit, is_last, tok_hs, last_hs, accept;

  // First index >= start that must be emitted; the top nibble always qualifies.
  function automatic logic [PW-1:0] find_pos(
    input logic [W_IN-1:0] w,
    input logic            s,
    input logic [PW:0]     start
  );
    logic found;
    find_pos = PW'(NG - 1);
    found    = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (!found && g >= int'(start) && (!s || w[GRP_W*g +: GRP_W] != '0)) begin
        find_pos = PW'(g);
        found    = 1'b1;
      end
    end
  endfunction

  assign nib = word_q[{pos_q, 2'b00} +: GRP_W];

  ecs_nibble_coder u_coder (
    .nib_i  (nib),
    .esc_o  (c_esc),
    .noi_o  (c_noi),
    .ind0_o (c_ind0),
    .ind1_o (c_ind1)
  );

  assign emit     = (state_q == S_EMIT) && !rst;
  assign is_last  = (pos_q == PW'(NG - 1));
  assign tok_hs   = emit && tok_ready;
  assign last_hs  = tok_hs && is_last;
  assign in_ready = !rst && ((state_q == S_IDLE) || last_hs);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    skip_d  = skip_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = S_EMIT;
      word_d  = in_data;
      skip_d  = in_skip;
      pos_d   = find_pos(in_data, in_skip, '0);
    end else if (last_hs) begin
      state_d = S_IDLE;
    end else if (tok_hs) begin
      pos_d = find_pos(word_q, skip_q, {1'b0, pos_q} + (PW+1)'(1));
    end
    if (tok_hs && c_esc && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      skip_q  <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      skip_q  <= skip_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tok_valid   = emit;
  assign tok_esc     = emit && c_esc;
  assign tok_payload = emit ? pack_payload(c_esc, nib, c_noi, c_ind0, c_ind1) : '0;
  assign tok_pos     = emit ? pos_q : '0;
  assign tok_last    = emit && is_last;
  assign esc_count   = cnt_q;

endmodule

// File: tb/tb_ecs_stream_encoder.sv
// Scoreboard bench: accepted words are expanded into expected tokens by a reference model; a monitor checks every token.
module tb_ecs_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_skip;
  logic        in_valid;
  logic        in_ready;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_esc;
  logic [5:0]  tok_payload;
  logic [1:0]  tok_pos;
  logic        tok_last;
  logic [3:0]  esc_count;

  typedef struct packed {
    logic       esc;
    logic [5:0] pay;
    logic [1:0] pos;
    logic       last;
  } tok_t;

  tok_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  int   cyc = 0;
  int   stall_until = 0;
  int   b2b_cnt = 0;
  bit   rand_ready = 0;
  bit   expect_valid_next = 0;
  bit   rst_seen = 0;
  bit   held_v = 0;
  tok_t held;

  ecs_stream_encoder #(.W_IN(16), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_skip     (in_skip),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_esc     (tok_esc),
    .tok_payload (tok_payload),
    .tok_pos     (tok_pos),
    .tok_last    (tok_last),
    .esc_count   (esc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (cyc < stall_until)  tok_ready = 1'b0;
    else if (rand_ready)    tok_ready = ($urandom_range(0, 3) != 0);
    else                    tok_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every nibble in order, zero nibbles dropped below the top one in skip mode.
  task automatic model_push(input logic [15:0] w, input logic s);
    for (int g = 0; g < 4; g++) begin
      logic [3:0] nib;
      int ones;
      int posl[2];
      tok_t t;
      nib = w[4*g +: 4];
      if (s && nib == 4'h0 && g < 3) continue;
      ones = 0;
      posl[0] = 0;
      posl[1] = 0;
      for (int b = 0; b < 4; b++) begin
        if (nib[b]) begin
          if (ones < 2) posl[ones] = b;
          ones++;
        end
      end
      t.esc  = (ones >= 3);
      t.pay  = t.esc ? {2'b00, nib} : {2'(ones), 2'(posl[0]), 2'(posl[1])};
      t.pos  = 2'(g);
      t.last = (g == 3);
      q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_tok_fields", {tok_valid, tok_esc, tok_payload, tok_pos, tok_last}, 0);
      q.delete();
      model_cnt = 0;
      held_v = 0;
      expect_valid_next = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) chk("in_ready_after_rst", in_ready, 1);
      rst_seen = 0;
      chk("esc_count", esc_count, model_cnt);
      if (expect_valid_next) chk("first_token_latency", tok_valid, 1);
      expect_valid_next = 0;
      if (held_v && tok_valid) chk("stall_stable", {tok_esc, tok_payload, tok_pos, tok_last}, held);
      held_v = 0;
      chk("in_ready_rule", in_ready, !tok_valid || (tok_ready && tok_last));
      if (tok_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_token", {tok_esc, tok_payload, tok_pos, tok_last}, 32'hDEAD);
        end else begin
          chk("token", {tok_esc, tok_payload, tok_pos, tok_last}, q[0]);
          if (tok_ready) begin
            if (q[0].esc && model_cnt < 15) model_cnt++;
            void'(q.pop_front());
          end else begin
            held   = {tok_esc, tok_payload, tok_pos, tok_last};
            held_v = 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (tok_valid) b2b_cnt++;
        model_push(in_data, in_skip);
        expect_valid_next = 1;
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic send_word(input logic [15:0] d, input logic s, input bit keep);
    bit ok = 0;
    in_data  = d;
    in_skip  = s;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %h not accepted within 200 cycles", d);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !tok_valid) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d tokens still pending", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    rst = 1'b1;
    in_data = '0;
    in_skip = 1'b0;
    in_valid = 1'b0;
    tok_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_esc_count", esc_count, 0);
    chk("reset_tok_valid", tok_valid, 0);
    @(posedge clk);
    #1;

    send_word(16'h0000, 1'b0, 1'b0);
    wait_drain();
    send_word(16'h8421, 1'b0, 1'b0);
    wait_drain();
    chk("esc_after_8421", esc_count, 0);
    send_word(16'hF0A0, 1'b1, 1'b0);
    wait_drain();
    chk("esc_after_F0A0", esc_count, 1);

    send_word(16'h7E31, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    stall_until = cyc + 3;
    wait_drain();
    chk("esc_after_7E31", esc_count, 3);

    b0 = b2b_cnt;
    send_word(16'h1234, 1'b0, 1'b1);
    send_word(16'h8001, 1'b1, 1'b0);
    wait_drain();
    chk("back_to_back_accepts", b2b_cnt - b0, 1);

    send_word(16'h7E31, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_word_rst_esc", esc_count, 0);
    chk("mid_word_rst_no_tok", tok_valid, 0);
    @(posedge clk);
    #1;
    send_word(16'h8421, 1'b0, 1'b0);
    wait_drain();

    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      logic [15:0] d, m;
      bit keep;
      d = 16'($urandom);
      m = 16'h0000;
      for (int g = 0; g < 4; g++) if ($urandom_range(0, 2) != 0) m[4*g +: 4] = 4'hF;
      keep = ($urandom_range(0, 2) == 0) && (i < 149);
      send_word(d & m, 1'($urandom_range(0, 1)), keep);
      if (!keep) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rand_ready = 0;
    for (int i = 0; i < 5; i++) send_word(16'hFFFF, 1'b0, 1'b0);
    wait_drain();
    chk("esc_saturated", esc_count, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecs_stream_encoder.md
ECS_STREAM_ENCODER -- requirements
Module: ecs_stream_encoder

Interface
REQ-001 Parameter W_IN, default 16: input word width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter CNT_W, default 16: width of the escape statistics counter.
REQ-003 Derived constant NG = W_IN/4 is the nibbles per word; PW = clog2(NG) is the position field width.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_data, input, W_IN: raw sparse word; nibble g is bits [4g+3:4g], with bit 4g at in-nibble position 0.
REQ-007 Port in_skip, input, 1: skip-zero mode for this word, sampled at acceptance.
REQ-008 Port in_valid / in_ready, input / output, 1 each: input handshake.
REQ-009 Port tok_valid / tok_ready, output / input, 1 each: token handshake.
REQ-010 Port tok_esc, output, 1: escape token, meaning the nibble has at least 3 ones.
REQ-011 Port tok_payload, output, 6: non-escape tokens carry {noi[1:0], ind0[1:0], ind1[1:0]}; escape tokens carry {2'b00, raw nibble[3:0]}.
REQ-012 Port tok_pos, output, PW: nibble index of the token.
REQ-013 Port tok_last, output, 1: final token of the word.
REQ-014 Port esc_count, output, CNT_W: saturating count of accepted escape tokens.

Function
REQ-015 Nibble coding: noi is the popcount (0..2); ind0 is the lowest set position and ind1 the second lowest set position; unused index fields SHALL be 0.
REQ-016 Popcount >= 3 SHALL produce tok_esc=1 with the raw nibble in the payload.
REQ-017 FSM states: IDLE and EMIT.
REQ-018 IDLE: in_ready=1 and tok_valid=0; in_valid=1 SHALL capture in_data and in_skip and move the FSM to EMIT.
REQ-019 Latency: the first token SHALL be valid in the cycle after acceptance.
REQ-020 EMIT: tok_valid=1; nibbles SHALL be emitted in ascending g order, advancing by one token per cycle in which tok_valid and tok_ready are both high.
REQ-021 Skip mode: with in_skip=1, zero nibbles g < NG-1 SHALL be skipped without consuming a cycle; nibble NG-1 SHALL always be emitted.
REQ-022 Without skip mode, exactly NG tokens SHALL be emitted per word.
REQ-023 tok_last=1 SHALL be asserted only on the token with tok_pos = NG-1.
REQ-024 Stall: while tok_valid=1 and tok_ready=0, tok_esc, tok_payload, tok_pos and tok_last SHALL hold stable.
REQ-025 in_ready SHALL be 1 in EMIT only when the tok_last token is handshaking that cycle.
REQ-026 Back-to-back: a word accepted in the same cycle as the tok_last handshake SHALL have its first token valid on the next cycle, with no bubble.
REQ-027 Without that back-to-back acceptance, the FSM SHALL return to IDLE after the tok_last handshake.
REQ-028 esc_count SHALL increment by 1 on each escape-token handshake and SHALL saturate at all-ones.

Reset
REQ-029 Reset SHALL force state=IDLE, in_ready=0 during reset, tok_valid=0, tok_esc=0, tok_payload=0, tok_pos=0, tok_last=0, esc_count=0, and clear the held word.
REQ-030 Reset asserted mid-word SHALL abandon the remaining tokens, emit no tok_last, and make in_ready=1 the first cycle after rst deasserts.

Structure
REQ-031 Shared package ecs_pkg SHALL hold the group-size constant 4, the payload width 6, the token field offsets, and the FSM state enum.
REQ-032 The per-nibble combinational coder SHALL be sub-module ecs_nibble_coder (4-bit input; esc, noi, ind0, ind1 outputs), instantiated once on the selected nibble.
REQ-033 Next-nonzero-nibble search logic SHALL live in the top level.

Verification (W_IN=16)
REQ-034 Input 16'h0000 with skip=0 -> 4 tokens, all noi=0, pos 0..3, tok_last on pos 3.
REQ-035 Input 16'h8421 with skip=0 -> tokens noi=1 with ind0 = 0, 1, 2, 3 at pos 0..3; esc_count stays 0.
REQ-036 Input 16'hF0A0 with skip=1 -> two tokens: pos1 {noi=2, ind0=1, ind1=3}, then pos3 with esc=1, raw=F, last=1; esc_count=1.
REQ-037 Input 16'h7E31 with tok_ready low for 3 cycles on the second token -> token fields stable throughout; sequence {1,0,0}, {2,0,1}, esc E, esc 7.
REQ-038 Two words presented with in_valid held high -> second word accepted in the cycle of the first word's tok_last handshake; no idle cycle on tok_valid.
REQ-039 rst pulsed during pos 1 of a word -> no further tokens, esc_count=0, and the next word encodes correctly from pos 0.
